// File: rtl/mul_add_seq.sv
// mul_add_seq: sequential shift-add multiply-accumulate, product = mcand * mplier + addend
module mul_add_seq #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   mcand,
  input  logic [W-1:0]   mplier,
  input  logic [W-1:0]   addend,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);
  localparam int CW = $clog2(W);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;
  logic [W-1:0] mc, mp;
  logic [2*W-1:0] acc, acc_nxt;
  logic [CW-1:0] cnt;
  logic accept, last;
  always_comb begin
    accept = (state != BUSY) && start;
    last = (state == BUSY) && (cnt == CW'(W - 1));
    acc_nxt = mp[cnt] ? acc + ({{W{1'b0}}, mc} << cnt) : acc;
    state_nxt = accept ? BUSY : last ? DONE : (state == BUSY) ? BUSY : IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mc <= '0;
      mp <= '0;
      acc <= '0;
      cnt <= '0;
      product <= '0;
    end else if (accept) begin
      mc <= mcand;
      mp <= mplier;
      acc <= {{W{1'b0}}, addend};
      cnt <= '0;
    end else if (state == BUSY) begin
      acc <= acc_nxt;
      cnt <= cnt + CW'(1);
      if (last) product <= acc_nxt;
    end
  assign busy = (state == BUSY);
  assign done = (state == DONE);
endmodule

// File: tb/tb_mul_add_seq.sv
// tb_mul_add_seq: directed and random checks of mul_add_seq against arithmetic reference
module tb_mul_add_seq;
  logic clk = 0, rst = 0, start = 0;
  logic [7:0] mcand = 0, mplier = 0, addend = 0;
  logic busy, done;
  logic [15:0] product;
  int checks = 0, errors = 0;

  mul_add_seq #(.W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .mcand(mcand), .mplier(mplier),
    .addend(addend), .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                    input logic [15:0] exp, input bit scr, input string tag);
    int bc, cyc;
    @(negedge clk);
    mcand = a; mplier = b; addend = c; start = 1;
    @(negedge clk);
    start = 0;
    bc = 0; cyc = 0;
    while (!done && cyc < 40) begin
      if (scr) begin start = 1; mcand = 9; mplier = 9; addend = 9; end
      if (busy) bc++;
      cyc++;
      @(negedge clk);
    end
    start = 0;
    chk({tag, " busy_cycles"}, bc, 8);
    chk({tag, " latency"}, cyc, 8);
    chk({tag, " done"}, done, 1);
    chk({tag, " product"}, product, exp);
    @(negedge clk);
    chk({tag, " done_pulse"}, {busy, done}, 0);
    chk({tag, " hold"}, product, exp);
  endtask

  initial begin
    int dt[$];
    logic [15:0] dp[$];
    int dnd, dor, nd;
    repeat (2) @(negedge clk);
    chk("reset", {busy, done, product}, 0);
    rst = 1;
    @(negedge clk);
    chk("idle", {busy, done, product}, 0);

    op(13, 7, 4, 95, 0, "t1");
    op(255, 255, 255, 16'hFF00, 0, "t2_max");
    op(0, 200, 9, 9, 0, "t2_zero");
    op(7, 28, 4, 200, 0, "t3_fixed");
    for (int i = 0; i < 50; i++) begin
      dnd = int'($urandom_range(0, 255));
      dor = int'($urandom_range(1, 255));
      op(8'(dor), 8'(dnd / dor), 8'(dnd % dor), 16'(dnd), 0, "t3_rt");
    end
    for (int i = 0; i < 10; i++) begin
      logic [7:0] a, b, c;
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
      op(a, b, c, 16'(int'(a) * int'(b) + int'(c)), 0, "rand");
    end
    op(3, 5, 1, 16, 1, "t4_scramble");

    @(negedge clk);
    mcand = 2; mplier = 3; addend = 0; start = 1;
    nd = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin mcand = 4; mplier = 4; addend = 1; end
      if (done) begin dt.push_back(c); dp.push_back(product); end
      if (busy) nd++;
    end
    start = 0;
    chk("t5_count", dt.size(), 2);
    if (dt.size() == 2) begin
      chk("t5_first", dt[0], 9);
      chk("t5_gap", dt[1] - dt[0], 9);
      chk("t5_p0", dp[0], 6);
      chk("t5_p1", dp[1], 17);
    end
    chk("t5_busy", nd, 18);
    repeat (12) @(negedge clk);
    chk("t5_idle", {busy, done}, 0);

    @(negedge clk);
    mcand = 100; mplier = 100; addend = 0; start = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    chk("t6_busy4", busy, 1);
    rst = 0;
    #1;
    chk("t6_async", {busy, done, product}, 0);
    nd = 0;
    repeat (12) begin @(negedge clk); if (done || busy) nd++; end
    chk("t6_nodone", nd, 0);
    chk("t6_product", product, 0);
    rst = 1;
    @(negedge clk);
    op(100, 100, 0, 10000, 0, "t6_fresh");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mul_add_seq.md
Name: mul_add_seq

Overview:
- Sequential shift-add multiply-accumulate unit. Computes product = mcand * mplier + addend.
- It is the inverse companion of the long divider: feeding it divisor, quotient and remainder reconstructs the dividend, so the bench and datapath can self-check divisions.
- Uses one adder iteration per multiplier bit, with a start/busy/done handshake and a small FSM.

Parameters:
- W, 8, operand width in bits; product is 2W bits. W >= 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset. Asserting low immediately forces the reset state; deassertion is sampled on clk.
- start  input  1  request a new operation. Sampled only in IDLE or DONE.
- mcand  input  W  multiplicand (e.g. divisor). Unsigned.
- mplier  input  W  multiplier (e.g. quotient). Unsigned.
- addend  input  W  value added to the product (e.g. remainder). Unsigned.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse when the result becomes valid.
- product  output  2W  result; held stable from the done cycle until the next accepted start.

Behaviour:
Reset (rst low):
- FSM goes to IDLE.
- busy=0, done=0, product=0.
- Internal accumulator, operand registers and bit counter are all cleared.

FSM states: IDLE, BUSY, DONE.

IDLE:
- busy=0, done=0, product holds its last value (0 after reset).
- If start=1 at a clk edge:
  - latch mcand into a W-bit register and mplier into a W-bit shift register;
  - load acc[2W-1:0] = {W'b0, addend};
  - clear counter;
  - next state BUSY.

BUSY (exactly W cycles, counter 0..W-1):
- Each cycle, if the current multiplier bit (bit index = counter) is 1, acc <= acc + (mcand << counter). This is a 2W-bit unsigned add.
- The shift-right form (acc upper half add + shift, multiplier consumed LSB first) is an acceptable implementation, provided the final value is identical.
- counter increments each cycle.
- On the cycle counter==W-1, next state is DONE and product <= final acc.
- busy=1 throughout. start is ignored; operand inputs may change freely after acceptance.

DONE (one cycle):
- done=1, busy=0, product valid.
- If start=1 in this cycle, it is accepted exactly as in IDLE (back-to-back operation) and the next state is BUSY.
- Otherwise the next state is IDLE.

Latency:
- start sampled at edge k.
- busy high for cycles k+1 .. k+W.
- done high in cycle k+W+1; product valid from that cycle.
- Fixed latency, independent of operand values; no early exit on mplier=0.

Width rules:
- Max result is (2^W-1)^2 + (2^W-1) = 2^2W - 2^W, which fits in 2W bits. No overflow output, no truncation.

Boundary conditions:
- start held high continuously: one operation per W+1 cycles (accepted in IDLE, then re-accepted in each DONE cycle).
- Reset mid-BUSY: operation abandoned, outputs zero, no done pulse. The first start after rst returns high behaves like a fresh operation.
- Unknown/X on start in BUSY must not disturb the state.

Test Plan:
1. W=8: reset low 2 cycles, release; start with mcand=13, mplier=7, addend=4 -> busy high exactly 8 cycles, done pulse 1 cycle, product=95, product holds 95 afterwards.
2. W=8: mcand=255, mplier=255, addend=255 -> product=0xFF00 (65280), no wrap. Also mcand=0, mplier=200, addend=9 -> product=9 after the full 8 busy cycles.
3. Divider round-trip, W=8: for dnd=200, dor=7 the divider gives q=28, r=4. Feed mcand=7, mplier=28, addend=4 -> product=200. Repeat over 50 random (dnd, dor!=0) pairs; every result must equal dnd.
4. Start pulses in every busy cycle of a 3*5+1 operation, with operands changed to 9/9/9 -> product=16, latency unchanged, no extra done.
5. start held high; operations 2*3+0 then 4*4+1 -> done pulses 9 cycles apart, products 6 then 17.
6. Assert rst low at busy cycle 4 of 100*100+0 -> product=0, busy=0, no done. Release, then run 100*100+0 -> product=10000.
